// File: rtl/apb_master_fsm.sv
// APB requester: runs one host command as a single SETUP/ACCESS transfer and returns the response.
// Optional build macro APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait states (rsp_error=11).
module apb_master_fsm #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic                    cmd_write,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   input  logic [2:0]              cmd_prot,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_error,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic                    sel,
   output logic                    enable,
   output logic                    write,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] strb,
   output logic [2:0]              prot,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic                    ready,
   input  logic                    slave_error,
   input  logic                    other_error
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master_fsm: TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t                r_state,     w_state;
   logic                  r_cmd_ready, w_cmd_ready;
   logic                  r_rsp_valid, w_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
   logic [1:0]            r_rsp_error, w_rsp_error;
   logic [ADDR_WIDTH-1:0] r_addr,      w_addr;
   logic                  r_sel,       w_sel;
   logic                  r_enable,    w_enable;
   logic                  r_write,     w_write;
   logic [DATA_WIDTH-1:0] r_wdata,     w_wdata;
   logic [STRB_WIDTH-1:0] r_strb,      w_strb;
   logic [2:0]            r_prot,      w_prot;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_error <= '0;
         r_addr      <= '0;
         r_sel       <= 1'b0;
         r_enable    <= 1'b0;
         r_write     <= 1'b0;
         r_wdata     <= '0;
         r_strb      <= '0;
         r_prot      <= '0;
`ifdef APB_TIMEOUT_EN
         r_wait_cnt  <= '0;
`endif
      end else begin
         r_state     <= w_state;
         r_cmd_ready <= w_cmd_ready;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_rdata <= w_rsp_rdata;
         r_rsp_error <= w_rsp_error;
         r_addr      <= w_addr;
         r_sel       <= w_sel;
         r_enable    <= w_enable;
         r_write     <= w_write;
         r_wdata     <= w_wdata;
         r_strb      <= w_strb;
         r_prot      <= w_prot;
`ifdef APB_TIMEOUT_EN
         r_wait_cnt  <= w_wait_cnt;
`endif
      end
   end

   // Every output is computed one cycle ahead so the flops present it for the next state.
   always_comb begin
      w_state     = r_state;
      w_cmd_ready = 1'b0;
      w_rsp_valid = r_rsp_valid;
      w_rsp_rdata = r_rsp_rdata;
      w_rsp_error = r_rsp_error;
      w_addr      = r_addr;
      w_sel       = 1'b0;
      w_enable    = 1'b0;
      w_write     = r_write;
      w_wdata     = r_wdata;
      w_strb      = r_strb;
      w_prot      = r_prot;
`ifdef APB_TIMEOUT_EN
      w_wait_cnt  = r_wait_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            w_cmd_ready = 1'b1;
            if (cmd_valid && r_cmd_ready) begin
               w_state     = S_SETUP;
               w_cmd_ready = 1'b0;
               w_sel       = 1'b1;
               w_addr      = cmd_addr;
               w_write     = cmd_write;
               w_wdata     = cmd_wdata;
               w_strb      = cmd_write ? cmd_strb : '0;
               w_prot      = cmd_prot;
            end
         end
         S_SETUP: begin
            w_state  = S_ACCESS;
            w_sel    = 1'b1;
            w_enable = 1'b1;
`ifdef APB_TIMEOUT_EN
            w_wait_cnt = '0;
`endif
         end
         S_ACCESS: begin
            w_sel    = 1'b1;
            w_enable = 1'b1;
            if (ready) begin
               w_state     = S_RESP;
               w_sel       = 1'b0;
               w_enable    = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_error = slave_error ? 2'b01 : (other_error ? 2'b10 : 2'b00);
               w_rsp_rdata = (!r_write && !slave_error && !other_error) ? rdata : '0;
            end
`ifdef APB_TIMEOUT_EN
            else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_state     = S_RESP;
               w_sel       = 1'b0;
               w_enable    = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_error = 2'b11;
               w_rsp_rdata = '0;
            end else begin
               w_wait_cnt = r_wait_cnt + 1'b1;
            end
`endif
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state     = S_IDLE;
               w_rsp_valid = 1'b0;
               w_cmd_ready = 1'b1;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_error = r_rsp_error;
   assign addr      = r_addr;
   assign sel       = r_sel;
   assign enable    = r_enable;
   assign write     = r_write;
   assign wdata     = r_wdata;
   assign strb      = r_strb;
   assign prot      = r_prot;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm: inputs change on negedge, outputs are sampled on negedge.
// Responses are predicted into exp_q when a command is driven and popped when rsp_valid appears.
module tb_apb_master_fsm;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TB_TO = 4;

   logic          clk;
   logic          rstn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic          cmd_write;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic [2:0]    cmd_prot;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_error;
   logic [AW-1:0] addr;
   logic          sel;
   logic          enable;
   logic          write;
   logic [DW-1:0] wdata;
   logic [SW-1:0] strb;
   logic [2:0]    prot;
   logic [DW-1:0] rdata;
   logic          ready;
   logic          slave_error;
   logic          other_error;

   int n_checks = 0;
   int n_errors = 0;
   logic [DW+1:0] exp_q[$];

   apb_master_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TB_TO)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .addr(addr), .sel(sel), .enable(enable), .write(write), .wdata(wdata), .strb(strb),
      .prot(prot), .rdata(rdata), .ready(ready), .slave_error(slave_error),
      .other_error(other_error)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
      chk({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
      chk({tag, "_sel"}, 64'(sel), 64'd0);
      chk({tag, "_enable"}, 64'(enable), 64'd0);
      chk({tag, "_bus"}, 64'({addr, write, wdata, strb, prot} != '0), 64'd0);
   endtask

   task automatic junk_cmd();
      cmd_addr  = $urandom;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_wdata = $urandom;
      cmd_strb  = 4'($urandom_range(0, 15));
      cmd_prot  = 3'($urandom_range(0, 7));
   endtask

   // Driver for one full transfer; entered and left just after a negedge with the DUT idle.
   task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, input logic [2:0] pr, input int waits,
                       input logic [DW-1:0] rd, input logic se, input logic oe,
                       input int hold, input logic pend);
      logic [SW-1:0] exp_strb;
      logic [1:0]    exp_err;
      logic [DW-1:0] exp_rd;
      logic [DW+1:0] exp;
      exp_strb = wr ? st : '0;
      exp_err  = se ? 2'b01 : (oe ? 2'b10 : 2'b00);
      exp_rd   = (!wr && exp_err == 2'b00) ? rd : '0;
      chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("idle_sel", 64'(sel), 64'd0);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_write = wr;
      cmd_wdata = wd;
      cmd_strb  = st;
      cmd_prot  = pr;
      exp_q.push_back({exp_err, exp_rd});
      @(negedge clk);
      cmd_valid = 1'b0;
      junk_cmd();
      chk("setup_sel", 64'(sel), 64'd1);
      chk("setup_enable", 64'(enable), 64'd0);
      chk("setup_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("setup_bus", 64'({addr, write, wdata, strb, prot} === {a, wr, wd, exp_strb, pr}), 64'd1);
      @(negedge clk);
      for (int i = 0; i <= waits; i++) begin
         chk("access_sel", 64'(sel), 64'd1);
         chk("access_enable", 64'(enable), 64'd1);
         chk("access_bus", 64'({addr, write, wdata, strb, prot} === {a, wr, wd, exp_strb, pr}), 64'd1);
         if (i == waits) begin
            ready = 1'b1; rdata = rd; slave_error = se; other_error = oe;
         end else begin
            ready = 1'b0; rdata = $urandom;
            slave_error = 1'($urandom_range(0, 1)); other_error = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      ready = 1'b0; rdata = $urandom;
      slave_error = 1'($urandom_range(0, 1)); other_error = 1'($urandom_range(0, 1));
      chk("resp_sel", 64'(sel), 64'd0);
      chk("resp_enable", 64'(enable), 64'd0);
      chk("resp_valid", 64'(rsp_valid), 64'd1);
      chk("resp_bus_kept", 64'(addr === a && wdata === wd), 64'd1);
      chk("scoreboard_nonempty", 64'(exp_q.size() > 0), 64'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("rsp_error", 64'(rsp_error), 64'(exp[DW+1:DW]));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp[DW-1:0]));
      cmd_valid = pend;
      for (int h = 0; h < hold; h++) begin
         rsp_ready = 1'b0;
         @(negedge clk);
         chk("hold_valid", 64'(rsp_valid), 64'd1);
         chk("hold_fields", 64'({rsp_error, rsp_rdata} === exp), 64'd1);
         chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
         chk("hold_sel", 64'(sel), 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("done_valid", 64'(rsp_valid), 64'd0);
      chk("done_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("done_sel", 64'(sel), 64'd0);
   endtask

   initial begin
      rstn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
      rdata = '0; ready = 1'b0; slave_error = 1'b0; other_error = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rstn = 1'b1;
      @(negedge clk);
      chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

      // zero-wait write, then read with three wait states (strobes must read back 0)
      xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 32'h0BAD0BAD, 1'b0, 1'b0, 0, 1'b0);
      xfer(1'b0, 32'h24, 32'h55AA55AA, 4'hF, 3'b010, 3, 32'h12345678, 1'b0, 1'b0, 0, 1'b0);
      // error precedence
      xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'b001, 1, 32'hCAFEF00D, 1'b1, 1'b1, 0, 1'b0);
      xfer(1'b0, 32'h34, 32'h0, 4'h0, 3'b001, 0, 32'hCAFEF00D, 1'b0, 1'b1, 0, 1'b0);
      xfer(1'b1, 32'h38, 32'h1, 4'h3, 3'b100, 2, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 1'b0);
      // response back-pressure with a pending command; next SETUP follows directly
      xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 0, 32'hA5A5A5A5, 1'b0, 1'b0, 5, 1'b1);
      xfer(1'b1, 32'h44, 32'h11223344, 4'h5, 3'b011, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0);

      for (int k = 0; k < 6; k++) begin
         xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), $urandom_range(0, TB_TO - 2), $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
      end

`ifdef APB_TIMEOUT_EN
      // ready stuck low: abort after TB_TO ACCESS cycles
      cmd_valid = 1'b1; cmd_addr = 32'h50; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0;
      cmd_prot = '0;
      exp_q.push_back({2'b11, 32'h0});
      @(negedge clk);
      cmd_valid = 1'b0;
      ready = 1'b0; rdata = 32'hFEEDFACE;
      @(negedge clk);
      for (int i = 0; i < TB_TO; i++) begin
         chk("to_access_enable", 64'(enable), 64'd1);
         @(negedge clk);
      end
      chk("to_resp_valid", 64'(rsp_valid), 64'd1);
      chk("to_sel", 64'(sel), 64'd0);
      chk("to_enable", 64'(enable), 64'd0);
      chk("to_rsp", 64'({rsp_error, rsp_rdata}), 64'(exp_q.pop_front()));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("to_done_cmd_ready", 64'(cmd_ready), 64'd1);
      // ready arriving on the last allowed cycle completes normally
      xfer(1'b0, 32'h54, 32'h0, 4'h0, 3'b000, TB_TO - 1, 32'h87654321, 1'b0, 1'b0, 0, 1'b0);
`else
      // without the timeout a long wait still completes normally
      xfer(1'b0, 32'h54, 32'h0, 4'h0, 3'b000, 12, 32'h87654321, 1'b0, 1'b0, 0, 1'b0);
`endif

      // reset during ACCESS with ready low
      chk("pre_abort_cmd_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_addr = 32'h60; cmd_write = 1'b1; cmd_wdata = 32'h77; cmd_strb = 4'hF;
      cmd_prot = 3'b111;
      @(negedge clk);
      cmd_valid = 1'b0;
      ready = 1'b0;
      @(negedge clk);
      chk("abort_in_access", 64'(enable), 64'd1);
      rstn = 1'b0;
      @(negedge clk);
      chk_all_zero("abort");
      rstn = 1'b1;
      @(negedge clk);
      chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
      chk("abort_sel", 64'(sel), 64'd0);

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
